// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and issues one instruction-memory request at a time.
// It buffers the returned word for the decode stage and squashes in-flight or buffered
// work on an execute-stage redirect.
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt/squash_cnt performance counters.

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,

    // instruction memory request / response
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,

    // decode interface
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    output logic            inst_err,
    input  logic            inst_ready,

    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]     fetch_cnt,
    output logic [31:0]     squash_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_d;
    logic              r_kill;
    logic              w_kill_d;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   w_inst_d;
    logic [XLEN-1:0]   r_inst_pc;
    logic [XLEN-1:0]   w_inst_pc_d;
    logic              r_inst_err;
    logic              w_inst_err_d;

    logic [XLEN-1:0]   w_redirect_pc;
    logic [XLEN-1:0]   w_pc_inc;
    logic              w_unused_redirect_lsb;

    // Redirect targets are forced to word alignment; the low bits carry no meaning.
    assign w_redirect_pc         = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
    assign w_pc_inc              = r_pc + XLEN'(4);

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_inst_err <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_kill     <= w_kill_d;
            r_inst     <= w_inst_d;
            r_inst_pc  <= w_inst_pc_d;
            r_inst_err <= w_inst_err_d;
        end
    end

    // Next-state logic: fetch sequencing, redirect handling and response capture
    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_kill_d     = r_kill;
        w_inst_d     = r_inst;
        w_inst_pc_d  = r_inst_pc;
        w_inst_err_d = r_inst_err;

        unique case (r_state)
            StIdle: begin
                // One-cycle bubble after reset before the first request.
                if (redirect_valid) begin
                    w_pc_d = w_redirect_pc;
                end
                w_state_d = StReq;
            end

            StReq: begin
                if (redirect_valid) begin
                    w_pc_d = w_redirect_pc;
                end
                if (imem_req_ready) begin
                    // A redirect in the accept cycle still sends the old address, so its
                    // response must be thrown away when it returns.
                    w_kill_d  = redirect_valid;
                    w_state_d = StWait;
                end
            end

            StWait: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid || r_kill) begin
                        if (redirect_valid) begin
                            w_pc_d = w_redirect_pc;
                        end
                        w_kill_d  = 1'b0;
                        w_state_d = StReq;
                    end else begin
                        // Faulted fetches hand decode an all-zero word (illegal opcode).
                        w_inst_d     = imem_rsp_err ? '0 : imem_rsp_data;
                        w_inst_pc_d  = r_pc;
                        w_inst_err_d = imem_rsp_err;
                        w_state_d    = StHold;
                    end
                end else if (redirect_valid) begin
                    w_pc_d   = w_redirect_pc;
                    w_kill_d = 1'b1;
                end
            end

            StHold: begin
                // Redirect wins over a same-cycle consume; the buffered word is dropped.
                if (redirect_valid) begin
                    w_pc_d    = w_redirect_pc;
                    w_state_d = StReq;
                end else if (inst_ready) begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = StReq;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs are pure decodes of registered state
    assign imem_req_valid = (r_state == StReq);
    assign imem_addr      = r_pc;
    assign inst_valid     = (r_state == StHold);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_err       = r_inst_err;

`ifdef IFU_PERF_CNT_EN
    logic        w_fetch_fire;
    logic        w_squash;
    logic [63:0] r_fetch_cnt;
    logic [31:0] r_squash_cnt;

    assign w_fetch_fire = (r_state == StHold) && inst_ready && !redirect_valid;
    // A squash is either a response thrown away in WAIT or a held word dropped in HOLD.
    assign w_squash     = ((r_state == StWait) && imem_rsp_valid && (r_kill || redirect_valid))
                        || ((r_state == StHold) && redirect_valid);

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_fetch_fire) begin
                r_fetch_cnt <= r_fetch_cnt + 64'd1;
            end
            if (w_squash) begin
                r_squash_cnt <= r_squash_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios push expected decode words into a
// queue; a monitor pops and compares on every decode handshake.

module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_err;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    ifu_fetch #(
        .RESET_PC (RESET_PC),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_err       (inst_err),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // memory model configuration, written by the stimulus process only
    int          mem_lat  = 1;
    logic [31:0] mem_data = 32'h0000_0513;
    logic        mem_err  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the fetch unit to present an instruction; ends on a negedge.
    task automatic wait_hold(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {95'd0, inst_valid}, 96'd1);
    endtask

    // Memory: accepts on valid&&ready, answers mem_lat cycles later with a one-cycle pulse.
    initial begin
        logic        acc;
        int          pend;
        int          lat_l;
        logic [31:0] d_l;
        logic        e_l;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        pend  = 0;
        lat_l = 1;
        d_l   = '0;
        e_l   = 1'b0;
        forever begin
            @(negedge clk);
            acc = !rst && imem_req_valid && imem_req_ready;
            if (acc) begin
                lat_l = mem_lat;
                d_l   = mem_data;
                e_l   = mem_err;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_rsp_err   = 1'b0;
            if (acc) pend = lat_l;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = d_l;
                    imem_rsp_err   = e_l;
                end
            end
        end
    end

    // Monitor: every accepted decode handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready && !redirect_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_inst", {64'd0, inst}, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_inst", {64'd0, inst}, {64'd0, e.word});
                    chk("sb_inst_pc", {64'd0, inst_pc}, {64'd0, e.pc});
                    chk("sb_inst_err", {95'd0, inst_err}, {95'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_iv;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
        chk("rst_inst_valid", {95'd0, inst_valid}, 96'd0);
        chk("rst_inst_regs", {31'd0, inst_err, inst, inst_pc}, 96'd0);
        chk("rst_addr", {64'd0, imem_addr}, {64'd0, RESET_PC});
        rst = 1'b0;

        // first fetch: IDLE bubble, request in cycle 2
        @(negedge clk);
        chk("idle_bubble", {95'd0, imem_req_valid}, 96'd0);
        tick();
        @(negedge clk);
        chk("first_req", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0000});
        sb_q.push_back('{word: 32'h0000_0513, pc: 32'h8000_0000, err: 1'b0});
        wait_hold("first_hold");
        chk("first_inst", {32'd0, inst, inst_pc}, {32'd0, 32'h0000_0513, 32'h8000_0000});

        // decode stall: everything stable, no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("hold_stable", {30'd0, inst_valid, imem_req_valid, inst, inst_pc},
                {30'd0, 1'b1, 1'b0, 32'h0000_0513, 32'h8000_0000});
        end
        tick();
        inst_ready = 1'b1;
        mem_data   = 32'h0010_0093;
        @(negedge clk);
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("seq_req", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0004});
        sb_q.push_back('{word: 32'h0010_0093, pc: 32'h8000_0004, err: 1'b0});
        wait_hold("second_hold");

        // memory back-pressure, then redirect during the stall
        tick();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        mem_data       = 32'hBAD0_0100;
        @(negedge clk);
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0008});
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        mem_lat        = 4;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("stall_redirect", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0100});

        // redirect while waiting on a slow response
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        mem_lat        = 1;
        mem_data       = 32'hBAD0_0200;
        @(negedge clk);
        chk("wait_no_req", {95'd0, imem_req_valid}, 96'd0);
        tick();
        redirect_valid = 1'b0;
        saw_iv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_valid) saw_iv = 1'b1;
            if (imem_req_valid) break;
            tick();
        end
        chk("killed_rsp_dropped", {95'd0, saw_iv}, 96'd0);
        chk("wait_redirect_req", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0200});
        wait_hold("redirect_hold");
        chk("redirect_hold_inst", {32'd0, inst, inst_pc}, {32'd0, 32'hBAD0_0200, 32'h8000_0200});

        // redirect coincident with inst_ready in HOLD
        tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        mem_data       = 32'hDEAD_BEEF;
        mem_err        = 1'b1;
        @(negedge clk);
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("hold_redirect", {62'd0, inst_valid, imem_req_valid, imem_addr},
            {62'd0, 1'b0, 1'b1, 32'h8000_0300});
        sb_q.push_back('{word: 32'h0000_0000, pc: 32'h8000_0300, err: 1'b1});

        // access fault
        wait_hold("err_hold");
        chk("err_inst", {63'd0, inst_err, inst}, {63'd0, 1'b1, 32'h0000_0000});
        tick();
        inst_ready = 1'b1;
        mem_err    = 1'b0;
        @(negedge clk);

        // redirect in the request-accept cycle, then wrap at the top of memory
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        mem_data       = 32'hBAD0_0304;
        @(negedge clk);
        chk("pre_wrap_req", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h8000_0304});
        tick();
        redirect_valid = 1'b0;
        mem_data       = 32'h0000_0013;
        @(negedge clk);
        chk("accept_redirect_wait", {95'd0, imem_req_valid}, 96'd0);
        tick();
        @(negedge clk);
        chk("accept_redirect_req", {62'd0, inst_valid, imem_req_valid, imem_addr},
            {62'd0, 1'b0, 1'b1, 32'hFFFF_FFFC});
        sb_q.push_back('{word: 32'h0000_0013, pc: 32'hFFFF_FFFC, err: 1'b0});
        wait_hold("wrap_hold");
        tick();
        inst_ready = 1'b1;
        mem_lat    = 2;
        @(negedge clk);
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("wrap_addr", {63'd0, imem_req_valid, imem_addr}, {63'd0, 1'b1, 32'h0000_0000});

        // reset in WAIT; the late response must be ignored
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_wait_state", {95'd0, imem_req_valid}, 96'd0);
        tick();
        rst      = 1'b0;
        mem_lat  = 1;
        mem_data = 32'h0000_0513;
        @(negedge clk);
        chk("reset_mid_regs", {29'd0, inst_valid, imem_req_valid, inst_err, inst, inst_pc}, 96'd0);
        tick();
        @(negedge clk);
        chk("reset_late_rsp", {62'd0, inst_valid, imem_req_valid, imem_addr},
            {62'd0, 1'b0, 1'b1, RESET_PC});
        sb_q.push_back('{word: 32'h0000_0513, pc: 32'h8000_0000, err: 1'b0});
        wait_hold("post_reset_hold");
        tick();
        inst_ready = 1'b1;
        @(negedge clk);
        tick();
        inst_ready = 1'b0;
        @(negedge clk);

        chk("sb_drained", {64'd0, 32'(sb_q.size())}, 96'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
